// File: rtl/rps_pkg.sv
`default_nettype none
// rps_pkg: state, result and move encodings shared by the RPS match controller.
// Revision: 1.0
package rps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_JUDGE   = 3'd2,
    ST_REPORT  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] RES_TIE  = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_VOID = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [2:0] MV_R = 3'b100;
  localparam logic [2:0] MV_P = 3'b010;
  localparam logic [2:0] MV_S = 3'b001;

  localparam int TIMEOUT_CYC = 64;

  function automatic logic mv_legal(input logic [2:0] m);
    return (m == MV_R) || (m == MV_P) || (m == MV_S);
  endfunction

  function automatic logic mv_beats(input logic [2:0] a, input logic [2:0] b);
    return ((a == MV_R) && (b == MV_S)) ||
           ((a == MV_S) && (b == MV_P)) ||
           ((a == MV_P) && (b == MV_R));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rps_judge.sv
`default_nettype none
// rps_judge: combinational round resolution of two moves into a 2-bit result.
// Revision: 1.0
module rps_judge
  import rps_pkg::*;
(
  input  logic [2:0] mv1_i,
  input  logic [2:0] mv2_i,
  output logic [1:0] result_o
);

  logic legal1;
  logic legal2;

  assign legal1 = mv_legal(mv1_i);
  assign legal2 = mv_legal(mv2_i);

  // An illegal move always loses; two illegal moves void the round.
  always_comb begin
    result_o = RES_VOID;
    if (!legal1 && !legal2) begin
      result_o = RES_VOID;
    end else if (!legal1) begin
      result_o = RES_P2;
    end else if (!legal2) begin
      result_o = RES_P1;
    end else if (mv1_i == mv2_i) begin
      result_o = RES_TIE;
    end else if (mv_beats(mv1_i, mv2_i)) begin
      result_o = RES_P1;
    end else begin
      result_o = RES_P2;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rps_match_ctrl.sv
`default_nettype none
// rps_match_ctrl: best-of match controller for two RPS players; define
// RPS_MATCH_TIMEOUT_EN to forfeit players who do not move within TIMEOUT_CYC. Revision: 1.0
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mv1_valid,
  input  logic [2:0]         mv1,
  input  logic               mv2_valid,
  input  logic [2:0]         mv2,
  output logic               mv1_ready,
  output logic               mv2_ready,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [SCORE_W-1:0] tie_cnt,
  output logic               round_done,
  output logic [1:0]         round_result,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] TIE_SAT  = '1;

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         mv1_q;
  logic [2:0]         mv2_q;
  logic               got1_q;
  logic               got2_q;
  logic [SCORE_W-1:0] score1_q;
  logic [SCORE_W-1:0] score2_q;
  logic [SCORE_W-1:0] tie_q;
  logic [1:0]         result_q;
  logic [1:0]         winner_q;
  logic [1:0]         judge_res;
  logic               acc1;
  logic               acc2;
  logic               both_in;
  logic               reached;
  logic               tmo_hit;

  assign acc1     = mv1_valid && mv1_ready;
  assign acc2     = mv2_valid && mv2_ready;
  assign both_in  = (got1_q || acc1) && (got2_q || acc2);
  assign reached  = (score1_q == TARGET) || (score2_q == TARGET);

`ifdef RPS_MATCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  // Restarts on every entry to COLLECT because it is held at zero elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q != ST_COLLECT) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ST_COLLECT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  rps_judge u_judge (
    .mv1_i    (mv1_q),
    .mv2_i    (mv2_q),
    .result_o (judge_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COLLECT;
      ST_COLLECT: if (both_in || tmo_hit) state_d = ST_JUDGE;
      ST_JUDGE:   state_d = ST_REPORT;
      ST_REPORT:  state_d = reached ? ST_DONE : ST_COLLECT;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    mv1_ready    = (state_q == ST_COLLECT) && !got1_q;
    mv2_ready    = (state_q == ST_COLLECT) && !got2_q;
    round_done   = (state_q == ST_REPORT);
    round_result = (state_q == ST_REPORT) ? result_q : RES_TIE;
    match_done   = (state_q == ST_DONE);
    match_winner = winner_q;
    score1       = score1_q;
    score2       = score2_q;
    tie_cnt      = tie_q;
  end

  // Moves are cleared to 000 on entering COLLECT, so a never-latched move reads as illegal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv1_q  <= '0;
      mv2_q  <= '0;
      got1_q <= 1'b0;
      got2_q <= 1'b0;
    end else if ((state_q != ST_COLLECT) && (state_d == ST_COLLECT)) begin
      mv1_q  <= '0;
      mv2_q  <= '0;
      got1_q <= 1'b0;
      got2_q <= 1'b0;
    end else begin
      if (acc1) begin
        mv1_q  <= mv1;
        got1_q <= 1'b1;
      end
      if (acc2) begin
        mv2_q  <= mv2;
        got2_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score1_q <= '0;
      score2_q <= '0;
      tie_q    <= '0;
      result_q <= RES_TIE;
      winner_q <= WIN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            score1_q <= '0;
            score2_q <= '0;
            tie_q    <= '0;
            winner_q <= WIN_NONE;
          end
        end
        ST_JUDGE: begin
          result_q <= judge_res;
          case (judge_res)
            RES_TIE: if (tie_q != TIE_SAT) tie_q <= tie_q + 1'b1;
            RES_P1:  score1_q <= score1_q + 1'b1;
            RES_P2:  score2_q <= score2_q + 1'b1;
            default: ;
          endcase
        end
        ST_REPORT: begin
          if (reached) winner_q <= (score1_q == TARGET) ? WIN_P1 : WIN_P2;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rps_match_ctrl.sv
`default_nettype none
// tb_rps_match_ctrl: table, directed and randomized checks against a behavioural RPS model.
// Revision: 1.0
module tb_rps_match_ctrl;

  localparam int WT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mv1_valid = 1'b0;
  logic [2:0] mv1 = 3'b000;
  logic       mv2_valid = 1'b0;
  logic [2:0] mv2 = 3'b000;
  logic       mv1_ready, mv2_ready;
  logic [7:0] score1, score2, tie_cnt;
  logic       round_done, match_done, busy;
  logic [1:0] round_result, match_winner;

  rps_match_ctrl #(.WIN_TARGET(WT), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mv1_valid(mv1_valid), .mv1(mv1), .mv2_valid(mv2_valid), .mv2(mv2),
    .mv1_ready(mv1_ready), .mv2_ready(mv2_ready),
    .score1(score1), .score2(score2), .tie_cnt(tie_cnt),
    .round_done(round_done), .round_result(round_result),
    .match_done(match_done), .match_winner(match_winner), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'b100, P = 3'b010, S = 3'b001;

  int n_chk = 0;
  int n_fail = 0;
  int m_s1 = 0, m_s2 = 0, m_tie = 0;

  typedef struct {
    logic [2:0] m1;
    logic [2:0] m2;
    int         exp;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mv_idx(input logic [2:0] m);
    return m[2] ? 0 : (m[1] ? 1 : 2);
  endfunction

  // Rock=0, paper=1, scissors=2: (a-b) mod 3 == 1 means a wins.
  function automatic int ref_result(input logic [2:0] a, input logic [2:0] b);
    bit la, lb;
    int d;
    la = ($countones(a) == 1);
    lb = ($countones(b) == 1);
    if (!la && !lb) return 3;
    if (!la) return 2;
    if (!lb) return 1;
    d = (mv_idx(a) - mv_idx(b) + 3) % 3;
    return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, {mv1_ready, mv2_ready}, 0);
    chk({tag, "_scores"}, {score1, score2, tie_cnt}, 0);
    chk({tag, "_pulses"}, {round_done, match_done, round_result, match_winner}, 0);
  endtask

  task automatic start_match();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_s1 = 0; m_s2 = 0; m_tie = 0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_clear", {score1, score2, tie_cnt, match_winner}, 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_and_start();
    rst = 1'b1;
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    start_match();
  endtask

  // Entered just after a rising edge in COLLECT; leaves at the falling edge of the REPORT cycle.
  task automatic do_round(input logic [2:0] a, input logic [2:0] b, input int da, input int db,
                          input bit noise, output bit seen, output int res);
    bit l1, l2;
    int k_hs, k_rd, last;
    l1 = 0; l2 = 0; seen = 0; k_hs = -1; k_rd = -1; res = -1;
    last = (da > db) ? da : db;
    for (int k = 0; k < last + 8; k++) begin
      mv1_valid = (k >= da) && (!l1 || noise);
      mv1       = l1 ? ~a : a;
      mv2_valid = (k >= db) && (!l2 || noise);
      mv2       = l2 ? ~b : b;
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (round_done) begin
        seen = 1; k_rd = k; res = round_result;
        break;
      end
      if (mv1_valid && mv1_ready && !l1) begin l1 = 1; k_hs = k; end
      if (mv2_valid && mv2_ready && !l2) begin l2 = 1; k_hs = k; end
      @(posedge clk); #1;
    end
    mv1_valid = 0; mv2_valid = 0; start = 0;
    if (!seen) chk("round_timeout", 0, 1);
    else chk("round_latency", k_rd, k_hs + 2);
  endtask

  task automatic play(input logic [2:0] a, input logic [2:0] b, input int da, input int db,
                      input bit noise, input int exp);
    bit seen;
    int res, r;
    do_round(a, b, da, db, noise, seen, res);
    if (!seen) begin
      $display("FAIL round_stall: got no round_done expected one at %0t", $time);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "stalled");
    end
    r = ref_result(a, b);
    chk("round_result", res, r);
    if (exp >= 0) chk("table_result", res, exp);
    case (r)
      0: m_tie = (m_tie < 255) ? m_tie + 1 : 255;
      1: m_s1++;
      2: m_s2++;
      default: ;
    endcase
    chk("score1", score1, m_s1);
    chk("score2", score2, m_s2);
    chk("tie_cnt", tie_cnt, m_tie);
    @(posedge clk); #1;
    if (m_s1 == WT || m_s2 == WT) begin
      @(negedge clk);
      chk("match_done", {match_done, round_done}, 2'b10);
      chk("match_winner", match_winner, (m_s1 == WT) ? 1 : 2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_busy", {busy, match_done}, 0);
      chk("idle_hold", {score1, score2, match_winner}, {8'(m_s1), 8'(m_s2), 2'((m_s1 == WT) ? 1 : 2)});
      start_match();
    end
  endtask

  initial begin
    tbl[0]  = '{P, P, 0};
    tbl[1]  = '{3'b110, R, 2};
    tbl[2]  = '{3'b000, 3'b111, 3};
    tbl[3]  = '{R, S, 1};
    tbl[4]  = '{S, P, 1};
    tbl[5]  = '{P, R, 1};
    tbl[6]  = '{S, R, 2};
    tbl[7]  = '{R, P, 2};
    tbl[8]  = '{P, S, 2};
    tbl[9]  = '{R, R, 0};
    tbl[10] = '{S, S, 0};
    tbl[11] = '{R, 3'b000, 1};

    #1;
    chk_all_zero("por");
    reset_and_start();

    // Three p1 wins with p2 moving three cycles late.
    for (int i = 0; i < 3; i++) play(R, S, 0, 3, 0, 1);

    for (int i = 0; i < 12; i++) play(tbl[i].m1, tbl[i].m2, 0, 0, 0, tbl[i].exp);

    // Reset while JUDGE is resolving the match-winning round.
    reset_and_start();
    play(R, S, 0, 0, 0, 1);
    play(R, S, 0, 0, 0, 1);
    mv1 = R; mv2 = S; mv1_valid = 1; mv2_valid = 1;
    @(posedge clk); #1;
    mv1_valid = 0; mv2_valid = 0;
    rst = 1'b1;
    #1;
    chk_all_zero("judge_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_pulse", {round_done, match_done}, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    start_match();
    play(R, S, 0, 0, 0, 1);

    // Tie counter saturation with noisy start/valid during COLLECT.
    reset_and_start();
    for (int i = 0; i < 256; i++) play(P, P, 0, 0, (i % 4) == 0, 0);
    chk("tie_sat", tie_cnt, 255);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : (3'b100 >> $urandom_range(0, 2));
      b = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : (3'b100 >> $urandom_range(0, 2));
      play(a, b, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
    end

    // p2 never moves after p1 plays rock.
    mv1 = R; mv1_valid = 1;
    @(posedge clk); #1;
    mv1_valid = 0;
`ifdef RPS_MATCH_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (!round_done && k < 100) begin @(negedge clk); k++; end
      chk("timeout_result", {round_done, round_result}, 3'b101);
    end
`else
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (round_done) pulses++;
      end
      chk("wait_pulses", pulses, 0);
      chk("wait_collect", {busy, mv1_ready, mv2_ready}, 3'b101);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
